frame_sample_server: RTL and testbench

Responder side of the window request/response handshake in the MFCC front end. Accepts the continuous audio sample stream, buffers it in a circular RAM, and declares a frame ready once N samples are available. It then serves that frame one sample per request to the window stage and advances the frame start by HOP samples, giving overlapping frames.

---
 rtl/mfcc_frame_pkg.sv | 19 +
 rtl/frame_ram.sv | 28 ++
 rtl/frame_sample_server.sv | 181 ++++++++++++++++++
 tb/tb_frame_sample_server.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_frame_pkg.sv
// Shared types and defaults for the MFCC framing stage.
// Holds the frame server state encoding, default geometry and pre-emphasis shift.
package mfcc_frame_pkg;

  localparam int Q_IN_DEF      = 15;
  localparam int N_DEF         = 256;
  localparam int HOP_DEF       = 128;
  localparam int PREEMPH_SHIFT = 5;

  typedef enum logic [2:0] {
    IDLE,
    ANNOUNCE,
    ARMED,
    READ,
    RESPOND,
    LOCKOUT
  } state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample buffer: one write port, one read port,
// read data registered one cycle after the address is presented.
module frame_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array and read register are not reset; contents are don't-care
  // after reset, and a reset would stop the array mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_sample_server.sv
// Buffers the audio stream in a circular RAM and serves overlapping frames
// one sample per request. Optional pre-emphasis: define FRAME_PREEMPH_EN.
module frame_sample_server
  import mfcc_frame_pkg::*;
#(
  parameter int Q_IN = Q_IN_DEF,
  parameter int N    = N_DEF,
  parameter int HOP  = HOP_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic signed [Q_IN:0] sample_in,
  input  logic                 valid_request,
  output logic                 valid_packet,
  output logic                 valid_out,
  output logic signed [Q_IN:0] data_out,
  output logic                 overrun
);

  localparam int DEPTH = 2 * N;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         frame_start_q, frame_start_d;
  logic [AW-1:0]         rd_idx_q, rd_idx_d;
  logic                  valid_packet_q, valid_packet_d;
  logic                  valid_out_q, valid_out_d;
  logic signed [Q_IN:0]  data_out_q, data_out_d;
  logic                  overrun_q, overrun_d;

  logic [PW-1:0]         fill;
  logic                  full;
  logic                  ram_we, ram_re;
  logic [AW-1:0]         ram_waddr, ram_raddr;
  logic [Q_IN:0]         store_data, ram_rdata;

  // Pointers carry one extra bit so a completely full buffer differs from empty.
  assign fill      = wr_ptr_q - frame_start_q;
  assign full      = (fill == PW'(DEPTH));
  assign ram_waddr = wr_ptr_q[AW-1:0];
  assign ram_raddr = frame_start_q[AW-1:0] + rd_idx_q;

`ifdef FRAME_PREEMPH_EN
  localparam int SW = Q_IN + 3;

  logic signed [Q_IN:0] x_prev_q, x_prev_d;
  logic signed [SW-1:0] pe_x, pe_prev, pe_sum;

  // y = x - x_prev + x_prev/32, saturated back to the sample width.
  always_comb begin
    pe_x     = {{2{sample_in[Q_IN]}}, sample_in};
    pe_prev  = {{2{x_prev_q[Q_IN]}}, x_prev_q};
    pe_sum   = pe_x - pe_prev + (pe_prev >>> PREEMPH_SHIFT);
    x_prev_d = sample_valid ? sample_in : x_prev_q;
    if ((&pe_sum[SW-1:Q_IN]) || !(|pe_sum[SW-1:Q_IN])) begin
      store_data = pe_sum[Q_IN:0];
    end else if (pe_sum[SW-1]) begin
      store_data = {1'b1, {Q_IN{1'b0}}};
    end else begin
      store_data = {1'b0, {Q_IN{1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) x_prev_q <= '0;
    else       x_prev_q <= x_prev_d;
  end
`else
  assign store_data = sample_in;
`endif

  frame_ram #(
    .WIDTH (Q_IN + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (store_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    frame_start_d  = frame_start_q;
    rd_idx_d       = rd_idx_q;
    valid_packet_d = valid_packet_q;
    valid_out_d    = 1'b0;
    data_out_d     = data_out_q;
    overrun_d      = overrun_q;
    ram_we         = 1'b0;
    ram_re         = 1'b0;

    // Write side runs independently of the serving state.
    if (sample_valid) begin
      if (full) begin
        overrun_d = 1'b1;
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (fill >= PW'(N)) begin
          state_d        = ANNOUNCE;
          rd_idx_d       = '0;
          valid_packet_d = 1'b1;
        end
      end
      ANNOUNCE: begin
        if (valid_request) begin
          valid_packet_d = 1'b0;
          state_d        = READ;
        end
      end
      ARMED: begin
        if (valid_request) state_d = READ;
      end
      READ: begin
        ram_re  = 1'b1;
        state_d = RESPOND;
      end
      RESPOND: begin
        data_out_d  = ram_rdata;
        valid_out_d = 1'b1;
        rd_idx_d    = rd_idx_q + 1'b1;
        state_d     = LOCKOUT;
      end
      LOCKOUT: begin
        // Each request pulse yields one sample: wait for the level to drop.
        if (!valid_request) begin
          if (rd_idx_q == AW'(N)) begin
            frame_start_d = frame_start_q + PW'(HOP);
            state_d       = IDLE;
          end else begin
            state_d = ARMED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      frame_start_q  <= '0;
      rd_idx_q       <= '0;
      valid_packet_q <= 1'b0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      frame_start_q  <= frame_start_d;
      rd_idx_q       <= rd_idx_d;
      valid_packet_q <= valid_packet_d;
      valid_out_q    <= valid_out_d;
      data_out_q     <= data_out_d;
      overrun_q      <= overrun_d;
    end
  end

  assign valid_packet = valid_packet_q;
  assign valid_out    = valid_out_q;
  assign data_out     = data_out_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_frame_sample_server.sv
// Self-checking bench for frame_sample_server: a queue of stored samples,
// indexed by absolute sample number, predicts every served frame.
module tb_frame_sample_server;

  localparam int N     = 256;
  localparam int HOP   = 128;
  localparam int DEPTH = 512;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_valid;
  logic signed [15:0] sample_in;
  logic               valid_request;
  logic               valid_packet;
  logic               valid_out;
  logic signed [15:0] data_out;
  logic               overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: every accepted sample in arrival order.
  int stream[$];
  int m_wr;
  int m_fs;
`ifdef FRAME_PREEMPH_EN
  int m_xprev;
`endif

  frame_sample_server dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample_in     (sample_in),
    .valid_request (valid_request),
    .valid_packet  (valid_packet),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int store_val(input int x);
`ifdef FRAME_PREEMPH_EN
    int y;
    y = x - m_xprev + (m_xprev >>> 5);
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    return y;
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    stream.delete();
    m_wr = 0;
    m_fs = 0;
`ifdef FRAME_PREEMPH_EN
    m_xprev = 0;
`endif
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    sample_valid  = 1'b0;
    valid_request = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_vp"},   int'(valid_packet), 0);
    check({tag, "_vo"},   int'(valid_out), 0);
    check({tag, "_data"}, int'(data_out), 0);
    check({tag, "_ovr"},  int'(overrun), 0);
  endtask

  task automatic push(input int x);
    sample_in    = 16'(x);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    if (m_wr - m_fs < DEPTH) begin
      stream.push_back(store_val(x));
      m_wr++;
    end
`ifdef FRAME_PREEMPH_EN
    m_xprev = x;
`endif
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // One request pulse: valid_out must appear exactly two cycles after the
  // request is sampled, once, regardless of how long the request is held.
  task automatic serve_one(input int exp, input int hold, input string tag);
    valid_request = 1'b1;
    tick();
    check({tag, "_vo_t0"}, int'(valid_out), 0);
    check({tag, "_vp_t0"}, int'(valid_packet), 0);
    tick();
    check({tag, "_vo_t1"}, int'(valid_out), 0);
    tick();
    check({tag, "_vo_t2"}, int'(valid_out), 1);
    check({tag, "_data"},  int'(data_out), exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_vo_hold"}, int'(valid_out), 0);
    end
    valid_request = 1'b0;
    tick();
    check({tag, "_vo_end"}, int'(valid_out), 0);
  endtask

  task automatic wait_packet(input string tag);
    int n = 0;
    while (!valid_packet && n < 8) begin
      tick();
      n++;
    end
    check(tag, int'(valid_packet), 1);
  endtask

  task automatic serve_frame(input string tag, input int first_hold);
    wait_packet({tag, "_pkt"});
    for (int i = 0; i < N; i++) begin
      serve_one(stream[m_fs + i], (i == 0) ? first_hold : int'($urandom_range(2)), tag);
    end
    m_fs += HOP;
    check({tag, "_vp_after"}, int'(valid_packet), 0);
  endtask

  initial begin
    reset         = 1'b1;
    sample_valid  = 1'b0;
    sample_in     = '0;
    valid_request = 1'b0;

    do_reset();
    check_zero_outputs("reset");

    // Ramp frame; packet announced two cycles after the Nth sample.
    for (int i = 0; i < N - 1; i++) push(i);
    check("vp_before_full", int'(valid_packet), 0);
    push(N - 1);
    check("vp_cycle1", int'(valid_packet), 0);
    tick();
    check("vp_cycle2", int'(valid_packet), 1);
    serve_frame("ramp", 3);
    repeat (4) tick();
    check("vp_half_fill", int'(valid_packet), 0);

    // Overlapping frames with random data until pointers wrap past 2*DEPTH.
    while (m_wr < 2 * DEPTH) begin
      repeat (HOP) push(rnd_sample());
      serve_frame("hop", int'($urandom_range(3)));
    end
    check("ovr_clean", int'(overrun), 0);

    // Overrun: buffer full, next sample dropped and absent from later frames.
    do_reset();
    check_zero_outputs("reset2");
    repeat (DEPTH) push(rnd_sample());
    check("ovr_at_full", int'(overrun), 0);
    push(12345);
    check("ovr_dropped", int'(overrun), 1);
    serve_frame("ovr_f0", 0);
    repeat (HOP) push(rnd_sample());
    repeat (3) serve_frame("ovr_fn", 1);
    check("ovr_sticky", int'(overrun), 1);

    // Reset in the middle of a frame.
    repeat (HOP) push(rnd_sample());
    wait_packet("mid_pkt");
    for (int i = 0; i < 100; i++) serve_one(stream[m_fs + i], 0, "pre_reset");
    reset = 1'b1;
    tick();
    check_zero_outputs("mid_reset");
    reset = 1'b0;
    model_reset();
    repeat (N - 1) push(rnd_sample());
    repeat (4) tick();
    check("vp_after_reset", int'(valid_packet), 0);
    push(rnd_sample());
    serve_frame("post_reset", 2);

`ifdef FRAME_PREEMPH_EN
    // Constant input then alternating full-scale input through the filter.
    do_reset();
    repeat (HOP) push(32000);
    for (int i = 0; i < HOP; i++) push((i % 2 == 0) ? 32767 : -32767);
    serve_frame("preemph", 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
